// File: rtl/arb_pkg.sv
// Shared encodings for the memory-port arbiter and the pipeline controller.
// State and owner encodings, plus RV load/store opcodes.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-port request/grant/response bundle; master = arbiter, slave = memory.
// Request payload is held from m_req rise until m_gnt; response arrives on m_rvalid.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  m_req;
    logic                  m_we;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_wstrb;
    logic                  m_gnt;
    logic                  m_rvalid;
    logic [DATA_W-1:0]     m_rdata;

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        output m_gnt, m_rvalid, m_rdata
    );
endinterface

// File: rtl/arb_priority_sel.sv
// Winner selection between IF and MEM with an anti-starvation counter for IF.
// Latency: combinational grant; starve_cnt updates on arbitration cycles (arb_en).
// Backpressure: none; the caller only samples grant_mem when it can start a transaction.
module arb_priority_sel #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic mem_req,
    input  logic arb_en,
    output logic grant_mem
);
    localparam int CW = 4;

    logic [CW-1:0] starve_cnt;
    logic          contested;
    logic          starved;

    always_comb begin
        contested = if_req & mem_req;
        starved   = (starve_cnt == CW'(STARVE_MAX));
        grant_mem = mem_req & ~(contested & starved);
    end

    // A contested MEM win can only happen below STARVE_MAX, so the increment saturates there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (if_req && !grant_mem) begin
                starve_cnt <= '0;
            end else if (contested) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF fetch and MEM load/store; ARB_PERF_EN adds perf counters.
// Latency: >=3 cycles from IDLE sample to done (ISSUE, WAIT, DONE), plus one IDLE cycle between ops.
// Backpressure: requesters stall until done; m_req and payload are held until m_gnt.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [31:0]           if_rdata,
    output logic                  if_done,
    output logic                  if_stall,
    input  logic                  flush,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_done,
    output logic                  mem_stall,
`ifdef ARB_PERF_EN
    output logic [31:0]           perf_conflict,
    output logic [31:0]           perf_discard,
`endif
    mem_port_arbiter_if.master    mp
);
    arb_state_t            state, state_nxt;
    arb_owner_t            owner;
    logic                  grant_mem;
    logic                  arb_en;
    logic                  discard;
    logic                  sel_hi;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic                  if_kill;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^if_addr[1:0];
    assign arb_en          = (state == IDLE) && (if_req || mem_req);
    // A flush landing in DONE itself still kills the fetch result.
    assign if_kill         = discard | flush;

    arb_priority_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .mem_req   (mem_req),
        .arb_en    (arb_en),
        .grant_mem (grant_mem)
    );

    always_comb begin
        state_nxt = state;
        if_done   = 1'b0;
        mem_done  = 1'b0;
        case (state)
            IDLE:    if (arb_en) state_nxt = ISSUE;
            ISSUE:   if (mp.m_gnt) state_nxt = WAIT;
            WAIT:    if (mp.m_rvalid) state_nxt = DONE;
            DONE: begin
                state_nxt = IDLE;
                if_done   = (owner == OWN_IF) && if_req && !if_kill;
                mem_done  = (owner == OWN_MEM) && mem_req;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign if_stall   = if_req & ~if_done;
    assign mem_stall  = mem_req & ~mem_done;
    assign mp.m_req   = (state == ISSUE);
    assign mp.m_we    = we_q;
    assign mp.m_addr  = addr_q;
    assign mp.m_wdata = wdata_q;
    assign mp.m_wstrb = wstrb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            discard   <= 1'b0;
            sel_hi    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (arb_en) begin
                if (grant_mem) begin
                    owner   <= OWN_MEM;
                    we_q    <= mem_we;
                    addr_q  <= mem_addr;
                    wdata_q <= mem_wdata;
                    wstrb_q <= mem_wstrb;
                end else begin
                    owner   <= OWN_IF;
                    we_q    <= 1'b0;
                    addr_q  <= {if_addr[ADDR_W-1:3], 3'b000};
                    wdata_q <= '0;
                    wstrb_q <= '0;
                    sel_hi  <= if_addr[2];
                end
            end
            if (state == DONE) begin
                discard <= 1'b0;
            end else if (state != IDLE && owner == OWN_IF && flush) begin
                discard <= 1'b1;
            end
            if (state == WAIT && mp.m_rvalid) begin
                if (owner == OWN_IF) begin
                    if (!if_kill) if_rdata <= sel_hi ? mp.m_rdata[63:32] : mp.m_rdata[31:0];
                end else if (!we_q) begin
                    mem_rdata <= mp.m_rdata;
                end
            end
        end
    end

`ifdef ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_conflict <= '0;
            perf_discard  <= '0;
        end else begin
            if (state == IDLE && if_req && mem_req) perf_conflict <= perf_conflict + 32'd1;
            if (state == DONE && owner == OWN_IF && if_kill) perf_discard <= perf_discard + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch (IF) requester and the MEM-stage load/store requester of the 5-stage RV64 pipeline.
- Sequences every memory transaction with a request/grant/response handshake.
- Drives stall signals back to the pipeline controller.
- Discards fetch responses that a branch-mispredict flush has made stale.

Parameters:
- ADDR_W, 32, address width on both requesters and the memory port.
- DATA_W, 64, memory data width; fixed at 64 (strobe width is DATA_W/8).
- STARVE_MAX, 4, consecutive lost arbitrations after which IF gets priority; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request, held until if_done.
- if_addr  in  ADDR_W  fetch address; bit 2 selects the 32-bit word half.
- if_rdata  out  32  fetched instruction.
- if_done  out  1  one-cycle pulse: if_rdata valid.
- if_stall  out  1  if_req & ~if_done.
- flush  in  1  mispredict flush; kills any fetch in flight.
- mem_req  in  1  load/store request, held until mem_done.
- mem_we  in  1  1 = store.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_wstrb  in  DATA_W/8  byte strobes.
- mem_rdata  out  DATA_W  load data.
- mem_done  out  1  one-cycle completion pulse.
- mem_stall  out  1  mem_req & ~mem_done.
- m_req  out  1  memory request.
- m_we, m_addr, m_wdata, m_wstrb  out  request payload.
- m_gnt  in  1  memory accepts the request this cycle.
- m_rvalid  in  1  response or write-ack this cycle.
- m_rdata  in  DATA_W  response data.

Behaviour:
- Reset values (async, immediate on rst): state IDLE, all outputs 0, starve_cnt 0, discard 0.
- FSM states:
  - IDLE -> ISSUE when a request is pending and one is selected.
  - ISSUE: m_req=1 with the registered payload; -> WAIT on m_gnt.
  - WAIT: -> DONE on m_rvalid.
  - DONE: one cycle, pulses the owner's done; -> IDLE.
- Arbitration (in IDLE only, registered into owner):
  - Only one requester pending: it wins.
  - Both pending: MEM wins unless starve_cnt==STARVE_MAX, in which case IF wins.
  - starve_cnt increments (saturating) each time IF loses a contested arbitration and clears when IF is granted.
- Payload: latched at the IDLE->ISSUE transition. For IF: m_we=0, m_wstrb=0, m_addr={if_addr[ADDR_W-1:3],3'b0}.
- Handshake: m_req and the payload stay stable from ISSUE entry until m_gnt; m_req never drops early. m_rvalid is ignored outside WAIT.
- Data capture on m_rvalid in WAIT:
  - Owner IF: if_rdata <= if_addr[2] ? m_rdata[63:32] : m_rdata[31:0] (uses the latched address).
  - Owner MEM and load: mem_rdata <= m_rdata.
  - Store: data is ignored; only the ack counts.
- Latency: minimum 3 cycles from the IDLE sample of a request to done (ISSUE with m_gnt=1, WAIT with m_rvalid=1, DONE).
- rdata outputs hold their value until the next done for the same requester.
- Flush:
  - Owner IF in ISSUE, WAIT or DONE: set discard. If discard is set in DONE, if_done is suppressed.
  - Flush asserted in the same cycle as m_rvalid: discard still applies.
  - Flush in IDLE, or while owner is MEM: no effect.
  - discard clears on the return to IDLE.
- Requester drops its request mid-transaction: the transaction still completes on the memory side. done is pulsed only if the req is still high in DONE.
- Back-to-back: DONE -> IDLE costs one cycle; no combinational path from m_gnt or m_rvalid to any output.

Optional Feature:
- Macro ARB_PERF_EN.
- Defined:
  - Adds outputs perf_conflict (32 bit, counts IDLE cycles with both requests pending) and perf_discard (32 bit, counts discarded fetch responses).
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Package arb_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT, DONE as 2-bit constants);
  - the owner encoding (OWN_IF=0, OWN_MEM=1);
  - the RV opcode constants OP_LOAD=7'b0000011 and OP_STORE=7'b0100011, shared with the pipeline controller.
- Sub-module arb_priority_sel: combinational winner selection plus the saturating starve_cnt register (clk, rst, if_req, mem_req, arb_en -> grant_mem).

Test Plan:
- Single fetch: if_req=1, if_addr=0x104, m_gnt and m_rvalid immediate, m_rdata=0xAAAA_BBBB_1111_2222 -> m_addr=0x100, if_done 3 cycles later, if_rdata=0xAAAA_BBBB, if_stall low after done.
- Contention: if_req and mem_req both held, mem_we=0, STARVE_MAX=4 -> grant order MEM,MEM,MEM,MEM,IF, and starve_cnt returns to 0.
- Store with wait states: mem_we=1, mem_wstrb=0x0F, m_gnt delayed 3 cycles, m_rvalid delayed 2 cycles -> m_req and payload stable throughout, single mem_done pulse, mem_rdata unchanged.
- Flush in WAIT: fetch outstanding, flush pulsed, then m_rvalid -> no if_done, if_rdata unchanged, next fetch proceeds. With ARB_PERF_EN, perf_discard=1.
- Reset mid-op: rst asserted in WAIT -> m_req=0 and state IDLE immediately, no done pulse, a later stray m_rvalid is ignored.
- Flush coincident with m_rvalid -> response discarded.
